// File: rtl/spi_cmd_ctrl_if.sv
// Byte-level handshake between the SPI slave, the command controller and the
// controlled FSM.
interface spi_cmd_ctrl_if;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic [7:0] i_State;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;
  logic       o_Fsm_Step;
  logic       o_Fsm_Signal;
  logic [7:0] o_Err_Count;
  logic       o_Busy;

  modport slave (
    input  i_RX_DV, i_RX_Byte, i_State,
    output o_TX_DV, o_TX_Byte, o_Fsm_Step, o_Fsm_Signal, o_Err_Count, o_Busy
  );

  modport master (
    output i_RX_DV, i_RX_Byte, i_State,
    input  o_TX_DV, o_TX_Byte, o_Fsm_Step, o_Fsm_Signal, o_Err_Count, o_Busy
  );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// Decodes single-byte SPI commands: read FSM state, step the FSM with a 0/1
// input, or answer RESP_ERR. Every output is a flop.
module spi_cmd_ctrl #(
  parameter logic [7:0] CMD_READ = 8'hFF,
  parameter logic [7:0] CMD_IN0  = 8'h00,
  parameter logic [7:0] CMD_IN1  = 8'h01,
  parameter logic [7:0] RESP_ERR = 8'hEE
) (
  input logic           i_Clk,
  input logic           i_Rst,
  spi_cmd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    STEP    = 3'd2,
    SETTLE  = 3'd3,
    LOAD_TX = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [7:0] err_count_q, err_count_d;
  logic       tx_dv_q, tx_dv_d;
  logic       fsm_step_q, fsm_step_d;
  logic       fsm_signal_q, fsm_signal_d;
  logic       busy_q, busy_d;
  logic       bad_cmd;
  logic       overrun;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    tx_byte_d    = tx_byte_q;
    fsm_signal_d = fsm_signal_q;
    bad_cmd      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_RX_DV) begin
          cmd_d   = bus.i_RX_Byte;
          state_d = DECODE;
        end else begin
          state_d = IDLE;
        end
      end
      DECODE: begin
        if (cmd_q == CMD_READ) begin
          tx_byte_d = bus.i_State;
          state_d   = LOAD_TX;
        end else if ((cmd_q == CMD_IN0) || (cmd_q == CMD_IN1)) begin
          fsm_signal_d = cmd_q[0];
          state_d      = STEP;
        end else begin
          tx_byte_d = RESP_ERR;
          bad_cmd   = 1'b1;
          state_d   = LOAD_TX;
        end
      end
      STEP:    state_d = SETTLE;
      // The FSM has had a full cycle to transition; capture its new state.
      SETTLE: begin
        tx_byte_d = bus.i_State;
        state_d   = LOAD_TX;
      end
      LOAD_TX: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A byte arriving while busy is dropped; it shares one increment with a bad command.
    overrun = bus.i_RX_DV && (state_q != IDLE);
    if ((bad_cmd || overrun) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end

    tx_dv_d    = (state_d == LOAD_TX);
    fsm_step_d = (state_d == STEP);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q      <= IDLE;
      cmd_q        <= 8'h00;
      tx_byte_q    <= 8'h00;
      err_count_q  <= 8'h00;
      tx_dv_q      <= 1'b0;
      fsm_step_q   <= 1'b0;
      fsm_signal_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      tx_byte_q    <= tx_byte_d;
      err_count_q  <= err_count_d;
      tx_dv_q      <= tx_dv_d;
      fsm_step_q   <= fsm_step_d;
      fsm_signal_q <= fsm_signal_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.o_TX_DV      = tx_dv_q;
  assign bus.o_TX_Byte    = tx_byte_q;
  assign bus.o_Fsm_Step   = fsm_step_q;
  assign bus.o_Fsm_Signal = fsm_signal_q;
  assign bus.o_Err_Count  = err_count_q;
  assign bus.o_Busy       = busy_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed table, randomized traffic against an edge-timing reference model,
// and hand-written reset/saturation sequences for spi_cmd_ctrl.
module tb_spi_cmd_ctrl;

  localparam logic [7:0] CMD_READ = 8'hFF;
  localparam logic [7:0] CMD_IN0  = 8'h00;
  localparam logic [7:0] CMD_IN1  = 8'h01;
  localparam logic [7:0] RESP_ERR = 8'hEE;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_cmd_ctrl_if bus();

  spi_cmd_ctrl #(
    .CMD_READ (CMD_READ),
    .CMD_IN0  (CMD_IN0),
    .CMD_IN1  (CMD_IN1),
    .RESP_ERR (RESP_ERR)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic       dv;
    logic [7:0] rx;
    logic [7:0] st;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       step;
    logic       sig;
    logic [7:0] err;
    logic       busy;
  } vec_t;

  vec_t tbl[22];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a command accepted at edge e is busy through edge e+len,
  // acts on the FSM at e+1 and presents its response at e+len.
  int         n_edge;
  int         e_acc;
  int         m_len;
  logic       m_write;
  logic       m_bad;
  logic       m_bit;
  logic [7:0] m_tx;
  logic [7:0] m_err;
  logic       m_sig;

  function automatic logic m_busy(input int k);
    return (k >= e_acc) && (k <= e_acc + m_len);
  endfunction

  task automatic model_reset();
    n_edge  = 0;
    e_acc   = -100;
    m_len   = 1;
    m_write = 1'b0;
    m_bad   = 1'b0;
    m_bit   = 1'b0;
    m_tx    = 8'h00;
    m_err   = 8'h00;
    m_sig   = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h, expected %02h (vector %0d, t=%0t)", name, act, exp, vectors, $time);
    end
  endtask

  task automatic check_outputs(input logic e_dv, input logic [7:0] e_byte, input logic e_step,
                               input logic e_sig, input logic [7:0] e_err, input logic e_busy);
    vectors++;
    chk("tx_dv",   {7'd0, bus.o_TX_DV},      {7'd0, e_dv});
    chk("tx_byte", bus.o_TX_Byte,            e_byte);
    chk("step",    {7'd0, bus.o_Fsm_Step},   {7'd0, e_step});
    chk("signal",  {7'd0, bus.o_Fsm_Signal}, {7'd0, e_sig});
    chk("err_cnt", bus.o_Err_Count,          e_err);
    chk("busy",    {7'd0, bus.o_Busy},       {7'd0, e_busy});
  endtask

  task automatic drive(input logic dv, input logic [7:0] rx, input logic [7:0] st);
    bus.i_RX_DV   = dv;
    bus.i_RX_Byte = rx;
    bus.i_State   = st;
  endtask

  // Drive one cycle of inputs at the falling edge, predict, then check at the next falling edge.
  task automatic step_model(input logic dv, input logic [7:0] rx, input logic [7:0] st);
    logic inc;
    int   k;
    k   = n_edge + 1;
    inc = 1'b0;
    drive(dv, rx, st);
    if (dv) begin
      if (m_busy(n_edge)) begin
        inc = 1'b1;
      end else begin
        e_acc   = k;
        m_write = (rx == CMD_IN0) || (rx == CMD_IN1);
        m_bad   = !m_write && (rx != CMD_READ);
        m_len   = m_write ? 3 : 1;
        m_bit   = rx[0];
      end
    end
    if (k == e_acc + 1) begin
      if (m_write) m_sig = m_bit;
      if (m_bad) inc = 1'b1;
    end
    if (k == e_acc + m_len) m_tx = m_bad ? RESP_ERR : st;
    if (inc && (m_err != 8'hFF)) m_err = m_err + 8'd1;
    n_edge = k;
    @(posedge clk);
    @(negedge clk);
    check_outputs(k == e_acc + m_len, m_tx, m_write && (k == e_acc + 1), m_sig, m_err, m_busy(k));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [7:0] rnd8();
    logic [31:0] r;
    r = $urandom();
    return r[7:0];
  endfunction

  initial begin
    logic [7:0] b;
    int         pick;

    // {dv, rx, st | tx_dv, tx_byte, step, sig, err, busy}, one row per clock
    tbl[0]  = '{1'b1, 8'hFF, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 8'h05, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 8'h05, 1'b0, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 8'h01, 8'h02, 1'b0, 8'h05, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 8'h02, 1'b0, 8'h05, 1'b1, 1'b1, 8'h00, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 8'h03, 1'b0, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 8'h03, 1'b1, 8'h03, 1'b0, 1'b1, 8'h00, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 8'h03, 1'b0, 8'h03, 1'b0, 1'b1, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 8'h7A, 8'h03, 1'b0, 8'h03, 1'b0, 1'b1, 8'h00, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 8'h03, 1'b1, 8'hEE, 1'b0, 1'b1, 8'h01, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 8'h03, 1'b0, 8'hEE, 1'b0, 1'b1, 8'h01, 1'b0};
    tbl[11] = '{1'b1, 8'hFF, 8'h44, 1'b0, 8'hEE, 1'b0, 1'b1, 8'h01, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 8'h44, 1'b1, 8'h44, 1'b0, 1'b1, 8'h01, 1'b1};
    tbl[13] = '{1'b1, 8'h00, 8'h44, 1'b0, 8'h44, 1'b0, 1'b1, 8'h02, 1'b0};
    tbl[14] = '{1'b1, 8'h00, 8'h10, 1'b0, 8'h44, 1'b0, 1'b1, 8'h02, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 8'h10, 1'b0, 8'h44, 1'b1, 1'b0, 8'h02, 1'b1};
    tbl[16] = '{1'b1, 8'hCC, 8'h10, 1'b0, 8'h44, 1'b0, 1'b0, 8'h03, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 8'h11, 1'b1, 8'h11, 1'b0, 1'b0, 8'h03, 1'b1};
    tbl[18] = '{1'b0, 8'h00, 8'h11, 1'b0, 8'h11, 1'b0, 1'b0, 8'h03, 1'b0};
    tbl[19] = '{1'b1, 8'h7A, 8'h20, 1'b0, 8'h11, 1'b0, 1'b0, 8'h03, 1'b1};
    tbl[20] = '{1'b1, 8'h55, 8'h20, 1'b1, 8'hEE, 1'b0, 1'b0, 8'h04, 1'b1};
    tbl[21] = '{1'b0, 8'h00, 8'h20, 1'b0, 8'hEE, 1'b0, 1'b0, 8'h04, 1'b0};

    // Reset with a receive pulse held high; it must be ignored.
    rst = 1'b1;
    drive(1'b1, 8'hFF, 8'h5A);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check_outputs(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].dv, tbl[i].rx, tbl[i].st);
      @(posedge clk);
      @(negedge clk);
      check_outputs(tbl[i].tx_dv, tbl[i].tx_byte, tbl[i].step, tbl[i].sig, tbl[i].err, tbl[i].busy);
    end

    do_reset();
    for (int i = 0; i < 2000; i++) begin
      pick = $urandom_range(0, 3);
      case (pick)
        0:       b = CMD_READ;
        1:       b = CMD_IN0;
        2:       b = CMD_IN1;
        default: b = rnd8();
      endcase
      step_model(($urandom_range(0, 3) == 0), b, rnd8());
    end

    // Saturation: 300 bad commands, each followed by two idle cycles.
    for (int i = 0; i < 300; i++) begin
      step_model(1'b1, 8'h7A, rnd8());
      step_model(1'b0, 8'h00, rnd8());
      step_model(1'b0, 8'h00, rnd8());
    end
    vectors++;
    chk("err_saturated", bus.o_Err_Count, 8'hFF);

    // Reset asserted mid-write, while the step strobe is high.
    do_reset();
    step_model(1'b1, CMD_IN1, 8'h02);
    step_model(1'b0, 8'h00, 8'h02);
    rst = 1'b1;
    drive(1'b1, CMD_READ, 8'h3C);
    #1;
    check_outputs(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) step_model(1'b0, 8'h00, 8'h3C);
    step_model(1'b1, CMD_READ, 8'h3C);
    step_model(1'b0, 8'h00, 8'h3C);
    step_model(1'b0, 8'h00, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 SHALL have parameter CMD_READ, default 8'hFF, command requesting current FSM state.
REQ-002 SHALL have parameter CMD_IN0, default 8'h00, command feeding input 0 to FSM.
REQ-003 SHALL have parameter CMD_IN1, default 8'h01, command feeding input 1 to FSM.
REQ-004 SHALL have parameter RESP_ERR, default 8'hEE, response byte for unrecognised command.
REQ-005 SHALL have port i_Clk  input  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have port i_Rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port i_RX_DV  input  1  one-cycle pulse from SPI slave: received byte valid.
REQ-008 SHALL have port i_RX_Byte  input  8  received byte, valid while i_RX_DV high.
REQ-009 SHALL have port i_State  input  8  current FSM state, sampled as needed.
REQ-010 SHALL have port o_TX_DV  output  1  one-cycle pulse loading o_TX_Byte into SPI slave.
REQ-011 SHALL have port o_TX_Byte  output  8  response byte, stable from TX_DV cycle until next load.
REQ-012 SHALL have port o_Fsm_Step  output  1  one-cycle strobe advancing FSM with o_Fsm_Signal.
REQ-013 SHALL have port o_Fsm_Signal  output  1  FSM input bit, holds last written value.
REQ-014 SHALL have port o_Err_Count  output  8  saturating count of bad/dropped commands.
REQ-015 SHALL have port o_Busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, DECODE, STEP, SETTLE, LOAD_TX; all outputs registered/Moore.
REQ-017 IDLE: on edge E sampling i_RX_DV=1, SHALL latch i_RX_Byte and enter DECODE.
REQ-018 DECODE, byte==CMD_READ: SHALL load o_TX_Byte<=i_State, enter LOAD_TX (edge E+1).
REQ-019 DECODE, byte==CMD_IN0/CMD_IN1: SHALL set o_Fsm_Signal<=byte[0], enter STEP.
REQ-020 DECODE, any other byte: SHALL load o_TX_Byte<=RESP_ERR, increment o_Err_Count, enter LOAD_TX.
REQ-021 STEP: o_Fsm_Step SHALL be high exactly this one cycle; next state SETTLE.
REQ-022 SETTLE: SHALL wait one cycle, then load o_TX_Byte<=i_State (post-transition) and enter LOAD_TX.
REQ-023 LOAD_TX: o_TX_DV SHALL be high exactly this one cycle; next state IDLE.
REQ-024 Latency: read/error o_TX_DV high in cycle after E+1; write o_Fsm_Step after E+1, o_TX_DV after E+3.
REQ-025 i_RX_DV=1 in any non-IDLE state SHALL be dropped (no decode, no state change) and increment o_Err_Count.
REQ-026 o_Err_Count SHALL saturate at 8'hFF, never wrap; at most +1 per cycle even if overrun and bad command coincide.
REQ-027 o_TX_DV and o_Fsm_Step SHALL never be high in the same cycle.
REQ-028 A new i_RX_DV in the IDLE cycle immediately following LOAD_TX SHALL be accepted normally.
REQ-029 o_Fsm_Signal SHALL change only on write commands; read/error commands leave it unchanged.

Reset
REQ-030 i_Rst high SHALL immediately force IDLE, independent of i_Clk, aborting any in-flight command.
REQ-031 Reset values: o_TX_DV=0, o_TX_Byte=8'h00, o_Fsm_Step=0, o_Fsm_Signal=0, o_Err_Count=0, o_Busy=0.
REQ-032 i_RX_DV during reset SHALL be ignored; first pulse after release is processed normally.

Verification
REQ-033 Read: i_State=8'h05, RX 8'hFF -> o_TX_DV one cycle after E+1, o_TX_Byte=8'h05, o_Fsm_Step never high.
REQ-034 Write: RX 8'h01, i_State changes 8'h02->8'h03 after step -> o_Fsm_Signal=1, o_Fsm_Step pulse after E+1, o_TX_DV after E+3 with o_TX_Byte=8'h03.
REQ-035 Bad command: RX 8'h7A -> o_TX_Byte=8'hEE, o_TX_DV after E+1, o_Err_Count 0->1, o_Fsm_Signal unchanged.
REQ-036 Overrun: RX 8'h00 then second i_RX_DV two cycles later (in STEP) -> second byte dropped, o_Err_Count +1, one o_Fsm_Step, one o_TX_DV.
REQ-037 Saturation: 300 bad commands -> o_Err_Count stops at 8'hFF.
REQ-038 Reset mid-write: assert i_Rst in STEP -> all outputs to reset values asynchronously, no o_TX_DV follows.
